// File: rtl/cnn_pkg.sv
// Shared types and helpers for the pooling datapath.
package cnn_pkg;

  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;

  // Wide signed working type. Operands are sign-extended into it, and
  // results are cut back to the storage width by the caller.
  localparam int ACC_W = 32;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t pool_max(acc_t a, acc_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic acc_t pool_sum(acc_t a, acc_t b);
    return a + b;
  endfunction

  // Counter/address width. Never returns 0, so a one-entry range still
  // gets a 1-bit signal.
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Line buffer holding one partial result per output column and channel.
// Reads are asynchronous and writes are synchronous. Storage is rounded up
// to a power of two so that every address value is in range.
module pool_row_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = 14,
  parameter int WIDTH  = 9,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  assign rd_data = mem[rd_addr];

  // Write the even-row partial result.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/pool2x2_stream_engine.sv
// 2x2 / stride-2 max or average pooling over a channel-interleaved raster
// stream. It has one output register with ready/valid handshakes on both sides.
module pool2x2_stream_engine
  import cnn_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAP_W    = 28,
  parameter int MAP_H    = 28,
  parameter int CHANNELS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_avg,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     frame_done
);

  localparam int CH_W   = cnt_w(CHANNELS);
  localparam int COL_W  = cnt_w(MAP_W);
  localparam int ROW_W  = cnt_w(MAP_H);
  localparam int DEPTH  = (MAP_W / 2) * CHANNELS;
  localparam int ADDR_W = cnt_w(DEPTH);
  localparam int PART_W = DATA_W + 1;
  localparam int SUM_W  = DATA_W + 2;

  // The last column and row that are part of a 2x2 window. Beyond these,
  // an odd map size leaves a trailing column/row that is accepted and discarded.
  localparam logic [COL_W-1:0] LAST_COL = COL_W'((MAP_W / 2) * 2 - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'((MAP_H / 2) * 2 - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

  logic [CH_W-1:0]  ch;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  pool_mode_e       mode_q;

  logic [CHANNELS-1:0][DATA_W-1:0] hold;
  logic signed [DATA_W-1:0]        hold_sel;

  logic accept, keep, ch_wrap, col_wrap, row_wrap, first_beat;
  logic buf_we, emit, emit_last;
  logic [ADDR_W-1:0] buf_addr;
  logic signed [PART_W-1:0] part_rd, part_new;
  logic signed [SUM_W-1:0]  sum4, sum4_sh;
  logic signed [DATA_W-1:0] result;
  acc_t a_hold, a_pix, a_part, a_pair;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign ch_wrap    = (ch == LAST_CH);
  assign col_wrap   = (col == COL_W'(MAP_W - 1));
  assign row_wrap   = (row == ROW_W'(MAP_H - 1));
  assign first_beat = (ch == '0) && (col == '0) && (row == '0);
  assign keep       = (col <= LAST_COL) && (row <= LAST_ROW);

  // Column 2k and column 2k+1 share row-buffer slot k. Channels are interleaved inside the slot.
  assign buf_addr = ADDR_W'(32'(col >> 1) * 32'(CHANNELS) + 32'(ch));

  assign buf_we    = accept && keep && col[0] && !row[0];
  assign emit      = accept && keep && col[0] && row[0];
  assign emit_last = (col == LAST_COL) && (row == LAST_ROW) && ch_wrap;

  // Select the pair register of the current channel.
  always_comb begin
    hold_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (ch == CH_W'(c)) hold_sel = hold[c];
  end

  assign a_hold = acc_t'(hold_sel);
  assign a_pix  = acc_t'(in_data);
  assign a_part = acc_t'(part_rd);
  assign sum4   = SUM_W'(pool_sum(a_part, pool_sum(a_hold, a_pix)));
  assign sum4_sh = sum4 >>> 2;

  // Combine datapath: a horizontal pair feeds the row buffer, and a full
  // 2x2 window feeds the output register. A four-term sum fits in
  // DATA_W+2 bits. The arithmetic shift rounds toward -inf.
  always_comb begin
    a_pair   = '0;
    part_new = '0;
    result   = '0;
    if (mode_q == POOL_MAX) begin
      a_pair   = pool_max(a_hold, a_pix);
      part_new = PART_W'(a_pair);
      result   = DATA_W'(pool_max(a_part, a_pair));
    end else begin
      a_pair   = pool_sum(a_hold, a_pix);
      part_new = PART_W'(a_pair);
      result   = DATA_W'(sum4_sh);
    end
  end

  pool_row_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (PART_W),
    .ADDR_W(ADDR_W)
  ) u_rowbuf (
    .clk    (clk),
    .wr_en  (buf_we),
    .wr_addr(buf_addr),
    .wr_data(part_new),
    .rd_addr(buf_addr),
    .rd_data(part_rd)
  );

  // Position counters, the per-frame mode latch and the even-column pair registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch     <= '0;
      col    <= '0;
      row    <= '0;
      mode_q <= POOL_MAX;
      hold   <= '0;
    end else if (accept) begin
      if (first_beat) mode_q <= pool_mode_e'(cfg_avg);
      for (int c = 0; c < CHANNELS; c++)
        if (ch == CH_W'(c) && !col[0] && keep) hold[c] <= in_data;
      if (ch_wrap) begin
        ch <= '0;
        if (col_wrap) begin
          col <= '0;
          row <= row_wrap ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end else begin
        ch <= ch + CH_W'(1);
      end
    end
  end

  // Output register. A new result can load in the same cycle that the
  // previous one drains. frame_done follows the handshake of the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_last  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
